// File: rtl/alarm_siren_ctrl.sv
// alarm_siren_ctrl
// Drives the annunciators that follow the alarm state machine:
//  - pending    : entry-delay warning
//  - siren      : sounds for a fixed time, then silences itself
//  - strobe     : blinks while in the entry delay or while the siren sounds
//  - alarm_done : the siren has timed out and the system is still not disarmed
// It also keeps a 4-bit saturating count of siren activations.
// Every output is a register, so an input sampled at one rising edge is
// visible on the outputs just after that edge and never combinationally.

module alarm_siren_ctrl #(
    parameter int ENTRY_DELAY = 8,
    parameter int SIREN_TIME  = 32,
    parameter int BLINK_HALF  = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       disarmed,
    input  logic       armed,
    input  logic       triggered,
    output logic       pending,
    output logic       siren,
    output logic       strobe,
    output logic       alarm_done,
    output logic [3:0] alarm_count
);

    // Timer reload values. A phase that loads N-1 and leaves when the timer
    // reads zero lasts exactly N cycles.
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_ENTRY,
        S_SOUNDING,
        S_SILENCED
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] blink;

    // Qualified input requests. disarmed overrides everything else, and a
    // trigger without armed counts as armed plus triggered.
    logic req_disarm;
    logic req_arm;
    logic req_trig;

    assign req_disarm = disarmed;
    assign req_arm    = !disarmed && (armed || triggered);
    assign req_trig   = !disarmed && triggered;

    // Saturating increment of the 4-bit activation counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // The current blink half-period is complete.
    function automatic logic blink_wrap(input logic [CNT_W-1:0] b);
        return (b == BLINK_LAST);
    endfunction

    // State, timers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            blink       <= '0;
            alarm_count <= '0;
            pending     <= 1'b0;
            siren       <= 1'b0;
            strobe      <= 1'b0;
            alarm_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_arm) begin
                        state <= S_ARMED;
                    end
                end

                S_ARMED: begin
                    if (req_disarm) begin
                        state <= S_IDLE;
                    end else if (req_trig) begin
                        state   <= S_ENTRY;
                        timer   <= ENTRY_LOAD;
                        blink   <= '0;
                        strobe  <= 1'b1;
                        pending <= 1'b1;
                    end
                end

                S_ENTRY: begin
                    if (req_disarm) begin
                        // Abort during the entry delay: no siren, count unchanged.
                        state   <= S_IDLE;
                        pending <= 1'b0;
                        strobe  <= 1'b0;
                    end else if (timer == '0) begin
                        state       <= S_SOUNDING;
                        timer       <= SIREN_LOAD;
                        blink       <= '0;
                        strobe      <= 1'b1;
                        pending     <= 1'b0;
                        siren       <= 1'b1;
                        alarm_count <= sat_inc4(alarm_count);
                    end else begin
                        timer <= timer - 1'b1;
                        if (blink_wrap(blink)) begin
                            blink  <= '0;
                            strobe <= ~strobe;
                        end else begin
                            blink <= blink + 1'b1;
                        end
                    end
                end

                S_SOUNDING: begin
                    if (req_disarm) begin
                        state  <= S_IDLE;
                        siren  <= 1'b0;
                        strobe <= 1'b0;
                    end else if (timer == '0) begin
                        // Auto-silence; remain here until disarmed.
                        state      <= S_SILENCED;
                        siren      <= 1'b0;
                        strobe     <= 1'b0;
                        alarm_done <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                        if (blink_wrap(blink)) begin
                            blink  <= '0;
                            strobe <= ~strobe;
                        end else begin
                            blink <= blink + 1'b1;
                        end
                    end
                end

                S_SILENCED: begin
                    // A trigger that stays high does not re-sound the siren.
                    if (req_disarm) begin
                        state      <= S_IDLE;
                        alarm_done <= 1'b0;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    pending    <= 1'b0;
                    siren      <= 1'b0;
                    strobe     <= 1'b0;
                    alarm_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Testbench for alarm_siren_ctrl: directed scenarios followed by random
// stimulus, checked through a scoreboard queue fed by a phase-level model.

module tb_alarm_siren_ctrl;

    localparam int ED = 8;
    localparam int ST = 32;
    localparam int BH = 4;

    logic       clk;
    logic       reset;
    logic       disarmed;
    logic       armed;
    logic       triggered;
    logic       pending;
    logic       siren;
    logic       strobe;
    logic       alarm_done;
    logic [3:0] alarm_count;

    alarm_siren_ctrl #(
        .ENTRY_DELAY(ED),
        .SIREN_TIME (ST),
        .BLINK_HALF (BH),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .disarmed   (disarmed),
        .armed      (armed),
        .triggered  (triggered),
        .pending    (pending),
        .siren      (siren),
        .strobe     (strobe),
        .alarm_done (alarm_done),
        .alarm_count(alarm_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       p;
        logic       s;
        logic       st;
        logic       d;
        logic [3:0] c;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model: which phase the system is in, how many cycles have
    // elapsed in that phase, and how many alarms have sounded.
    localparam int M_IDLE   = 10;
    localparam int M_ARMED  = 20;
    localparam int M_ENTRY  = 30;
    localparam int M_SOUND  = 40;
    localparam int M_SILENT = 50;

    int m_phase   = M_IDLE;
    int m_elapsed = 0;
    int m_alarms  = 0;

    task automatic model_step(input bit d, input bit a, input bit t, input bit r);
        if (r) begin
            m_phase   = M_IDLE;
            m_elapsed = 0;
            m_alarms  = 0;
        end else if (d) begin
            m_phase   = M_IDLE;
            m_elapsed = 0;
        end else begin
            case (m_phase)
                M_IDLE:  if (a || t) m_phase = M_ARMED;
                M_ARMED: if (t) begin m_phase = M_ENTRY; m_elapsed = 0; end
                M_ENTRY: begin
                    if (m_elapsed + 1 >= ED) begin
                        m_phase   = M_SOUND;
                        m_elapsed = 0;
                        if (m_alarms < 15) m_alarms++;
                    end else m_elapsed++;
                end
                M_SOUND: begin
                    if (m_elapsed + 1 >= ST) m_phase = M_SILENT;
                    else m_elapsed++;
                end
                default: ;
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   blinking;
        blinking = (m_phase == M_ENTRY) || (m_phase == M_SOUND);
        e.p  = (m_phase == M_ENTRY);
        e.s  = (m_phase == M_SOUND);
        e.d  = (m_phase == M_SILENT);
        e.st = blinking && (((m_elapsed / BH) % 2) == 0);
        e.c  = 4'(m_alarms);
        return e;
    endfunction

    // One clock of stimulus: drive at the falling edge, then record the
    // response expected after the next rising edge.
    task automatic step(input bit d, input bit a, input bit t, input bit r);
        @(negedge clk);
        disarmed  = d;
        armed     = a;
        triggered = t;
        reset     = r;
        @(posedge clk);
        model_step(d, a, t, r);
        sb.push_back(model_out());
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pending",     {3'b0, pending},    {3'b0, e.p});
                check("siren",       {3'b0, siren},      {3'b0, e.s});
                check("strobe",      {3'b0, strobe},     {3'b0, e.st});
                check("alarm_done",  {3'b0, alarm_done}, {3'b0, e.d});
                check("alarm_count", alarm_count,        e.c);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        disarmed  = 1'b0;
        armed     = 1'b0;
        triggered = 1'b0;

        // Reset state.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Arm, trigger two cycles later, run through entry, siren and silence.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < ED + ST + 6; i++) step(0, 1, 1, 0);
        step(1, 0, 0, 0);

        // Disarm at the third pending cycle.
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        // Reset at the tenth siren cycle.
        step(0, 1, 1, 0);
        for (int i = 0; i < ED + 1 + 9; i++) step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        step(0, 0, 0, 0);

        // Seventeen full alarms to saturate the counter.
        for (int k = 0; k < 17; k++) begin
            step(0, 1, 1, 0);
            for (int i = 0; i < ED + ST + 3; i++) step(0, 1, 1, 0);
            step(1, 0, 0, 0);
        end

        // Simultaneous disarm and trigger in ARMED; trigger alone from IDLE.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, d, a, t;
            r = ($urandom_range(0, 299) == 0);
            d = ($urandom_range(0, 59) == 0);
            a = 1'($urandom_range(0, 1));
            t = ($urandom_range(0, 9) == 0);
            step(d, a, t, r);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", 4'(sb.size()), 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
